// File: rtl/ysyx_23060184_clint_pkg.sv
// ysyx_23060184_clint_pkg: CLINT register offsets, AXI response codes, FSM encodings and helper functions
package ysyx_23060184_clint_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [15:0] CLINT_MSIP_OFF = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF = 16'hBFF8;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic R_IDLE = 1'b0;
  localparam logic R_RESP = 1'b1;
  localparam logic W_IDLE = 1'b0;
  localparam logic W_RESP = 1'b1;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? d[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
  function automatic logic off_ok(input logic [15:0] off);
    return off == CLINT_MSIP_OFF || off == CLINT_MTIMECMP_OFF || off == CLINT_MTIMECMP_OFF + 16'd4 ||
           off == CLINT_MTIME_OFF || off == CLINT_MTIME_OFF + 16'd4;
  endfunction
endpackage

// File: rtl/ysyx_23060184_clint_timer.sv
// ysyx_23060184_clint_timer: prescaled 64-bit mtime, mtimecmp and registered mtip; we = {cmp_hi, cmp_lo, mtime_hi, mtime_lo} byte-masked writes
module ysyx_23060184_clint_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);
  import ysyx_23060184_clint_pkg::*;
  logic [31:0] cnt;
  logic tick;
  logic [63:0] mtime_n, cmp_n;
  assign tick = cnt == 32'(TICK_DIV - 1);
  always_comb begin
    mtime_n = we[0] ? {mtime[63:32], merge(mtime[31:0], wdata, wstrb)} :
              we[1] ? {merge(mtime[63:32], wdata, wstrb), mtime[31:0]} :
              tick  ? mtime + 64'd1 : mtime;
    cmp_n = we[2] ? {mtimecmp[63:32], merge(mtimecmp[31:0], wdata, wstrb)} :
            we[3] ? {merge(mtimecmp[63:32], wdata, wstrb), mtimecmp[31:0]} : mtimecmp;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      mtime <= '0;
      mtimecmp <= '1;
      mtip <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 32'd1;
      mtime <= mtime_n;
      mtimecmp <= cmp_n;
      mtip <= mtime_n >= cmp_n;
    end
  end
endmodule

// File: rtl/ysyx_23060184_clint_slave.sv
// ysyx_23060184_clint_slave: AXI4-Lite CLINT slave (AR/R, AW/W/B channels) driving mtip and msip
module ysyx_23060184_clint_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  mtip,
  output logic                  msip
);
  import ysyx_23060184_clint_pkg::*;
  logic r_state, w_state, aw_got, w_got, ar_fire, aw_fire, w_fire, commit;
  logic [15:0] roff, woff, awaddr_q;
  logic [31:0] wdata_q, wd, rd_val, shadow_hi;
  logic [3:0] wstrb_q, ws, we;
  logic [63:0] mtime, mtimecmp;
  logic unused_addr;
  assign unused_addr = ^{araddr[ADDR_WIDTH-1:16], awaddr[ADDR_WIDTH-1:16]};
  assign arready = r_state == R_IDLE;
  assign rvalid = r_state == R_RESP;
  assign awready = w_state == W_IDLE && !aw_got;
  assign wready = w_state == W_IDLE && !w_got;
  assign bvalid = w_state == W_RESP;
  assign ar_fire = arvalid && arready;
  assign aw_fire = awvalid && awready;
  assign w_fire = wvalid && wready;
  assign roff = araddr[15:0];
  // AW and W may arrive in either order; whichever came first is replayed from its capture register
  assign woff = aw_got ? awaddr_q : awaddr[15:0];
  assign wd = w_got ? wdata_q : wdata[31:0];
  assign ws = w_got ? wstrb_q : wstrb;
  assign commit = (aw_got || aw_fire) && (w_got || w_fire);
  assign we = {4{commit}} & {woff == CLINT_MTIMECMP_OFF + 16'd4, woff == CLINT_MTIMECMP_OFF,
                             woff == CLINT_MTIME_OFF + 16'd4, woff == CLINT_MTIME_OFF};
  // mtime hi returns the half captured by the last mtime lo read so a lo/hi pair is coherent
  always_comb
    rd_val = roff == CLINT_MSIP_OFF ? {31'd0, msip} :
             roff == CLINT_MTIMECMP_OFF ? mtimecmp[31:0] :
             roff == CLINT_MTIMECMP_OFF + 16'd4 ? mtimecmp[63:32] :
             roff == CLINT_MTIME_OFF ? mtime[31:0] :
             roff == CLINT_MTIME_OFF + 16'd4 ? shadow_hi : 32'd0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      rdata <= '0;
      rresp <= AXI_RESP_OKAY;
      bresp <= AXI_RESP_OKAY;
      shadow_hi <= '0;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      msip <= 1'b0;
    end else begin
      if (ar_fire) begin
        r_state <= R_RESP;
        rdata <= DATA_WIDTH'(rd_val);
        rresp <= off_ok(roff) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        if (roff == CLINT_MTIME_OFF) shadow_hi <= mtime[63:32];
      end else if (rvalid && rready) r_state <= R_IDLE;
      aw_got <= !commit && (aw_got || aw_fire);
      w_got <= !commit && (w_got || w_fire);
      if (aw_fire) awaddr_q <= awaddr[15:0];
      if (w_fire) begin
        wdata_q <= wdata[31:0];
        wstrb_q <= wstrb;
      end
      if (commit) begin
        w_state <= W_RESP;
        bresp <= off_ok(woff) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        if (woff == CLINT_MSIP_OFF && ws[0]) msip <= wd[0];
      end else if (bvalid && bready) w_state <= W_IDLE;
    end
  end
  ysyx_23060184_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk(clk),
    .rstn(rstn),
    .we(we),
    .wdata(wd),
    .wstrb(ws),
    .mtime(mtime),
    .mtimecmp(mtimecmp),
    .mtip(mtip)
  );
endmodule
